// File: rtl/axis_pkt_gen.sv
// AXI4-Stream master packet generator: num_pkts packets of pkt_len beats with incrementing tdata.
// Optional macro AXIS_PKT_GEN_CHKSUM_EN appends a per-packet sum beat carrying tlast.
module axis_pkt_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                    m00_axis_aclk,
  input  logic                    m00_axis_aresetn,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  input  logic [CNT_WIDTH-1:0]    num_pkts,
  input  logic [DATA_WIDTH-1:0]   first_data,
  output logic                    busy,
  output logic                    done,
  output logic                    m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  tvalid_q, tvalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
`ifdef AXIS_PKT_GEN_CHKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  chk_q, chk_d;
`endif

  logic xfer;
  logic last_payload;
  logic pkt_end;

  assign xfer         = tvalid_q & m00_axis_tready;
  assign last_payload = (beat_q == (len_q - LEN_WIDTH'(1)));

  assign busy            = busy_q;
  assign done            = done_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tstrb  = {(DATA_WIDTH/8){tvalid_q}};
`ifdef AXIS_PKT_GEN_CHKSUM_EN
  // data_q keeps the running sequence; the checksum beat only swaps what is shown on tdata.
  assign m00_axis_tdata  = chk_q ? sum_q : data_q;
  assign m00_axis_tlast  = tvalid_q & chk_q;
  assign pkt_end         = chk_q;
`else
  assign m00_axis_tdata  = data_q;
  assign m00_axis_tlast  = tvalid_q & last_payload;
  assign pkt_end         = last_payload;
`endif

  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;
    beat_d   = beat_q;
    len_d    = len_q;
    pkt_d    = pkt_q;
    num_d    = num_q;
    gap_d    = gap_q;
`ifdef AXIS_PKT_GEN_CHKSUM_EN
    sum_d    = sum_q;
    chk_d    = chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && (pkt_len != '0) && (num_pkts != '0)) begin
          len_d    = pkt_len;
          num_d    = num_pkts;
          data_d   = first_data;
          beat_d   = '0;
          pkt_d    = '0;
          busy_d   = 1'b1;
          tvalid_d = 1'b1;
          state_d  = S_SEND;
`ifdef AXIS_PKT_GEN_CHKSUM_EN
          sum_d    = '0;
          chk_d    = 1'b0;
`endif
        end
      end

      S_SEND: begin
        if (xfer) begin
`ifdef AXIS_PKT_GEN_CHKSUM_EN
          if (!chk_q) begin
            data_d = data_q + DATA_WIDTH'(1);
            sum_d  = sum_q + data_q;
            if (last_payload) chk_d = 1'b1;
            else              beat_d = beat_q + LEN_WIDTH'(1);
          end
`else
          data_d = data_q + DATA_WIDTH'(1);
          if (!last_payload) beat_d = beat_q + LEN_WIDTH'(1);
`endif
          if (pkt_end) begin
            beat_d = '0;
`ifdef AXIS_PKT_GEN_CHKSUM_EN
            sum_d  = '0;
            chk_d  = 1'b0;
`endif
            if (pkt_q == (num_q - CNT_WIDTH'(1))) begin
              tvalid_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end else begin
              pkt_d = pkt_q + CNT_WIDTH'(1);
              if (GAP_CYCLES != 0) begin
                tvalid_d = 1'b0;
                gap_d    = '0;
                state_d  = S_GAP;
              end
            end
          end
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          tvalid_d = 1'b1;
          state_d  = S_SEND;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      state_q  <= S_IDLE;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      pkt_q    <= '0;
      num_q    <= '0;
      gap_q    <= '0;
`ifdef AXIS_PKT_GEN_CHKSUM_EN
      sum_q    <= '0;
      chk_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      pkt_q    <= pkt_d;
      num_q    <= num_d;
      gap_q    <= gap_d;
`ifdef AXIS_PKT_GEN_CHKSUM_EN
      sum_q    <= sum_d;
      chk_q    <= chk_d;
`endif
    end
  end

endmodule
